// File: rtl/instr_fetch_stage_if.sv
// Instruction-memory fetch handshake between the IF stage and the instruction memory.
//   req   : fetch request, qualified with addr (driven by the fetch stage)
//   addr  : fetch address (driven by the fetch stage)
//   ready : rdata valid this cycle; only meaningful while req=1 (driven by memory)
//   rdata : fetched instruction word (driven by memory)
interface instr_fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] rdata;

  modport master (output req, output addr, input ready, input rdata);
  modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/instr_fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline: PC register, next-PC select, instruction
// memory req/ready handshake, one-entry hold buffer and the IF/ID pipeline register.
// Ports:
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   pc_write        : hazard unit PCWrite (0 = hold PC)
//   if_id_write     : hazard unit IF_IDWrite (0 = hold IF/ID)
//   branch_taken    : redirect request from EX (taken branch or jump)
//   branch_target   : redirect address
//   imem            : instruction-memory handshake (master side)
//   pc              : current fetch PC
//   if_id_instr     : IF/ID instruction word
//   if_id_pc_plus4  : IF/ID PC+4 of that instruction
//   if_id_valid     : 1 = real instruction, 0 = bubble
//   if_id_rs/rt     : source register fields of the IF/ID instruction
//   fetch_error     : sticky flag, set when memory never answers within WAIT_TIMEOUT
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0000,
  parameter int unsigned WAIT_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pc_write,
  input  logic                       if_id_write,
  input  logic                       branch_taken,
  input  logic [31:0]                branch_target,
  instr_fetch_stage_if.master        imem,
  output logic [31:0]                pc,
  output logic [31:0]                if_id_instr,
  output logic [31:0]                if_id_pc_plus4,
  output logic                       if_id_valid,
  output logic [4:0]                 if_id_rs,
  output logic [4:0]                 if_id_rt,
  output logic                       fetch_error
);

  localparam int CNT_W = $clog2(WAIT_TIMEOUT + 1);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    ERR   = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   wait_cnt;
  logic [31:0]        hold_instr;
  logic [31:0]        hold_pc_plus4;
  logic [31:0]        pc_plus4;
  logic               adv;

  assign adv      = pc_write & if_id_write;
  assign pc_plus4 = pc + 32'd4;

  // Only FETCH issues requests; HOLD already owns a word and ERR has given up.
  assign imem.req  = (state == FETCH) && !reset;
  assign imem.addr = pc;

  assign if_id_rs = if_id_instr[25:21];
  assign if_id_rt = if_id_instr[20:16];

  // Whole fetch FSM, PC, hold buffer and IF/ID register. A redirect outranks the
  // hazard unit's stall because the instructions behind a taken branch are dead.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= FETCH;
      wait_cnt       <= '0;
      pc             <= RESET_PC;
      hold_instr     <= NOP_INSTR;
      hold_pc_plus4  <= 32'd0;
      if_id_instr    <= NOP_INSTR;
      if_id_pc_plus4 <= 32'd0;
      if_id_valid    <= 1'b0;
      fetch_error    <= 1'b0;
    end else if (state != ERR && branch_taken) begin
      pc             <= branch_target;
      if_id_instr    <= NOP_INSTR;
      if_id_pc_plus4 <= 32'd0;
      if_id_valid    <= 1'b0;
      state          <= FETCH;
      wait_cnt       <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (imem.ready) begin
            wait_cnt <= '0;
            if (adv) begin
              if_id_instr    <= imem.rdata;
              if_id_pc_plus4 <= pc_plus4;
              if_id_valid    <= 1'b1;
              pc             <= pc_plus4;
            end else begin
              // Decode is stalled: park the word so it is not fetched twice.
              hold_instr    <= imem.rdata;
              hold_pc_plus4 <= pc_plus4;
              state         <= HOLD;
              if (if_id_write) begin
                if_id_instr    <= NOP_INSTR;
                if_id_pc_plus4 <= 32'd0;
                if_id_valid    <= 1'b0;
              end
            end
          end else begin
            if (if_id_write) begin
              if_id_instr    <= NOP_INSTR;
              if_id_pc_plus4 <= 32'd0;
              if_id_valid    <= 1'b0;
            end
            if (wait_cnt == CNT_W'(WAIT_TIMEOUT - 1)) begin
              state       <= ERR;
              fetch_error <= 1'b1;
            end
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        HOLD: begin
          if (adv) begin
            if_id_instr    <= hold_instr;
            if_id_pc_plus4 <= hold_pc_plus4;
            if_id_valid    <= 1'b1;
            pc             <= pc_plus4;
            state          <= FETCH;
          end else if (if_id_write) begin
            if_id_instr    <= NOP_INSTR;
            if_id_pc_plus4 <= 32'd0;
            if_id_valid    <= 1'b0;
          end
        end
        default: begin
          // ERR: stay put until reset, keep draining decode with bubbles.
          if (if_id_write) begin
            if_id_instr    <= NOP_INSTR;
            if_id_pc_plus4 <= 32'd0;
            if_id_valid    <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// word-availability model of the fetch stage.
module tb_instr_fetch_stage;

  localparam logic [31:0] NOP     = 32'h0000_0000;
  localparam int          TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_write;
  logic        if_id_write;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic [4:0]  if_id_rs;
  logic [4:0]  if_id_rt;
  logic        fetch_error;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  instr_fetch_stage_if imem_bus ();

  instr_fetch_stage #(
    .RESET_PC    (32'h0000_0000),
    .NOP_INSTR   (NOP),
    .WAIT_TIMEOUT(TIMEOUT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_write      (pc_write),
    .if_id_write   (if_id_write),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem          (imem_bus.master),
    .pc            (pc),
    .if_id_instr   (if_id_instr),
    .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_valid   (if_id_valid),
    .if_id_rs      (if_id_rs),
    .if_id_rt      (if_id_rt),
    .fetch_error   (fetch_error)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: tracks whether a fetched word is waiting for decode, the
  // run of unanswered requests, and what IF/ID must hold.
  logic [31:0] m_pc, m_instr, m_pc4, m_word;
  bit          m_valid, m_err, m_have;
  int          m_misses;

  always @(posedge clk) begin
    bit          adv, got;
    logic [31:0] word;
    adv  = pc_write && if_id_write;
    got  = m_have || imem_bus.ready;
    word = m_have ? m_word : imem_bus.rdata;
    if (reset) begin
      m_pc = 32'h0; m_instr = NOP; m_pc4 = 32'h0; m_valid = 0;
      m_err = 0; m_have = 0; m_misses = 0; m_word = 32'h0;
    end else if (m_err) begin
      if (if_id_write) begin m_instr = NOP; m_valid = 0; end
    end else if (branch_taken) begin
      m_pc = branch_target; m_instr = NOP; m_pc4 = 32'h0; m_valid = 0;
      m_have = 0; m_misses = 0;
    end else if (got && adv) begin
      m_instr = word; m_pc4 = m_pc + 32'd4; m_valid = 1;
      m_pc = m_pc + 32'd4; m_have = 0; m_misses = 0;
    end else begin
      if (if_id_write) begin m_instr = NOP; m_valid = 0; end
      if (!m_have) begin
        if (imem_bus.ready) begin
          m_have = 1; m_word = imem_bus.rdata; m_misses = 0;
        end else begin
          m_misses++;
          if (m_misses == TIMEOUT) m_err = 1;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checking) begin
      bit exp_req;
      exp_req = !reset && !m_err && !m_have;
      checkOutput("m_req", imem_bus.req, exp_req);
      if (exp_req) checkOutput("m_addr", imem_bus.addr, m_pc);
      checkOutput("m_pc", pc, m_pc);
      checkOutput("m_valid", if_id_valid, m_valid);
      checkOutput("m_instr", if_id_instr, m_instr);
      if (m_valid) checkOutput("m_pc4", if_id_pc_plus4, m_pc4);
      checkOutput("m_rs", if_id_rs, m_instr[25:21]);
      checkOutput("m_rt", if_id_rt, m_instr[20:16]);
      checkOutput("m_err", fetch_error, m_err);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit rst, input bit pw, input bit iw, input bit bt,
                               input logic [31:0] tgt, input bit rdy, input logic [31:0] data);
    reset          = rst;
    pc_write       = pw;
    if_id_write    = iw;
    branch_taken   = bt;
    branch_target  = tgt;
    imem_bus.ready = rdy;
    imem_bus.rdata = data;
  endtask

  initial begin
    int starve;
    applyStimulus(1, 0, 0, 0, 32'h0, 0, 32'h0);
    repeat (3) step();
    checking = 1'b1;
    checkOutput("rst_pc", pc, 32'h0);
    checkOutput("rst_valid", if_id_valid, 1'b0);
    checkOutput("rst_instr", if_id_instr, NOP);
    checkOutput("rst_err", fetch_error, 1'b0);
    checkOutput("rst_req", imem_bus.req, 1'b0);

    // Zero-wait memory streams one instruction per cycle.
    applyStimulus(0, 1, 1, 0, 32'h0, 1, 32'h1111_0000);
    #1;
    checkOutput("zw_addr0", imem_bus.addr, 32'h0);
    checkOutput("zw_req0", imem_bus.req, 1'b1);
    step();
    checkOutput("zw_addr1", imem_bus.addr, 32'h4);
    checkOutput("zw_pc4_1", if_id_pc_plus4, 32'h4);
    checkOutput("zw_val1", if_id_valid, 1'b1);
    imem_bus.rdata = 32'h1111_0004;
    step();
    checkOutput("zw_addr2", imem_bus.addr, 32'h8);
    checkOutput("zw_pc4_2", if_id_pc_plus4, 32'h8);
    imem_bus.rdata = 32'h1111_0008;
    step();
    checkOutput("zw_pc4_3", if_id_pc_plus4, 32'hC);
    checkOutput("zw_instr3", if_id_instr, 32'h1111_0008);

    // Stall while a word returns at pc=0x10: the word is held, not refetched.
    applyStimulus(0, 1, 1, 1, 32'h10, 0, 32'h0);
    step();
    checkOutput("hd_pc", pc, 32'h10);
    applyStimulus(0, 0, 0, 0, 32'h0, 1, 32'h8C22_0004);
    step();
    checkOutput("hd_req_a", imem_bus.req, 1'b0);
    checkOutput("hd_pc_a", pc, 32'h10);
    checkOutput("hd_instr_a", if_id_instr, NOP);
    imem_bus.ready = 0;
    step();
    checkOutput("hd_req_b", imem_bus.req, 1'b0);
    checkOutput("hd_valid_b", if_id_valid, 1'b0);
    applyStimulus(0, 1, 1, 0, 32'h0, 0, 32'h0);
    step();
    checkOutput("hd_instr", if_id_instr, 32'h8C22_0004);
    checkOutput("hd_pc4", if_id_pc_plus4, 32'h14);
    checkOutput("hd_valid", if_id_valid, 1'b1);
    checkOutput("hd_rs", if_id_rs, 5'd1);
    checkOutput("hd_rt", if_id_rt, 5'd2);

    // Redirect overrides a stall and drops the same-cycle word.
    applyStimulus(0, 0, 1, 1, 32'h40, 1, 32'hDEAD_BEEF);
    step();
    checkOutput("br_pc", pc, 32'h40);
    checkOutput("br_valid", if_id_valid, 1'b0);
    checkOutput("br_instr", if_id_instr, NOP);
    checkOutput("br_addr", imem_bus.addr, 32'h40);

    // Three wait cycles produce bubbles, then the word arrives.
    applyStimulus(0, 1, 1, 0, 32'h0, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("ws_bubble", if_id_valid, 1'b0);
    end
    applyStimulus(0, 1, 1, 0, 32'h0, 1, 32'h2002_0005);
    step();
    checkOutput("ws_valid", if_id_valid, 1'b1);
    checkOutput("ws_instr", if_id_instr, 32'h2002_0005);
    checkOutput("ws_err", fetch_error, 1'b0);

    // Memory never answers: sticky error, redirect ignored, reset recovers.
    applyStimulus(0, 1, 1, 0, 32'h0, 0, 32'h0);
    repeat (TIMEOUT - 1) step();
    checkOutput("to_err_early", fetch_error, 1'b0);
    step();
    checkOutput("to_err", fetch_error, 1'b1);
    checkOutput("to_req", imem_bus.req, 1'b0);
    applyStimulus(0, 1, 1, 1, 32'h80, 0, 32'h0);
    step();
    checkOutput("to_pc_kept", pc, 32'h44);
    checkOutput("to_err_kept", fetch_error, 1'b1);
    applyStimulus(1, 1, 1, 0, 32'h0, 0, 32'h0);
    step();
    checkOutput("to_rst_err", fetch_error, 1'b0);
    checkOutput("to_rst_pc", pc, 32'h0);

    // PC wraps past the top of the address space.
    applyStimulus(0, 1, 1, 1, 32'hFFFF_FFFC, 0, 32'h0);
    step();
    checkOutput("wr_pc", pc, 32'hFFFF_FFFC);
    applyStimulus(0, 1, 1, 0, 32'h0, 1, 32'h0123_4567);
    step();
    checkOutput("wr_pc0", pc, 32'h0);
    checkOutput("wr_pc4", if_id_pc_plus4, 32'h0);
    checkOutput("wr_valid", if_id_valid, 1'b1);

    // Randomized traffic, occasionally starving the memory long enough to time out.
    starve = 0;
    for (int c = 0; c < 3000; c++) begin
      bit rdy, rst;
      if (starve == 0 && $urandom_range(0, 299) == 0) starve = TIMEOUT + 6;
      if (starve > 0) starve--;
      rdy = (starve > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
      rst = (starve == 1) || ($urandom_range(0, 249) == 0);
      applyStimulus(rst, $urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0,
                    $urandom_range(0, 11) == 0, $urandom & 32'hFFFF_FFFC,
                    rdy, $urandom);
      step();
    end

    applyStimulus(0, 1, 1, 0, 32'h0, 1, 32'h0);
    step();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
